// File: rtl/vector_regcode_sequencer.sv
// Purpose: expands one vector-register request (base, count, stride) into a stream of 5-bit register codes {1'b1, index}.
// Latency: first code one cycle after acceptance, then one code per cycle; done pulses the cycle after the final handshake.
// Backpressure: code_ready low stalls the stream with outputs held; start_ready is high only while idle.
// Optional feature macro VECTOR_REGCODE_CHECK_EN: adds err and rejects count>16 (otherwise count>16 is clamped to 16).
module vector_regcode_sequencer #(
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [3:0]        base_vector,
  input  logic [4:0]        count,
  input  logic [STEP_W-1:0] step,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [4:0]        register_code,
  output logic              last,
  output logic              done,
  output logic              busy
`ifdef VECTOR_REGCODE_CHECK_EN
  ,
  output logic              err
`endif
);

  typedef enum logic {IDLE, EMIT} stateT;

  stateT      state, stateNext;
  logic [3:0] idx, idxNext;
  logic [4:0] rem, remNext;
  logic [3:0] stp, stpNext;
  logic       doneReg, doneNext;
  logic [4:0] effCount;
`ifdef VECTOR_REGCODE_CHECK_EN
  logic       errReg, errNext;
  logic       overRange;
`endif

  // Stride is applied modulo 16: only the low nibble ever matters.
  logic [3:0] stepLow;
  assign stepLow = 4'(step);

  // Outputs decode straight from registered state; start_ready is also held low during reset.
  assign start_ready   = (state == IDLE) && !rst;
  assign code_valid    = (state == EMIT);
  assign busy          = (state == EMIT);
  assign register_code = {1'b1, idx};
  assign last          = (state == EMIT) && (rem == 5'd1);
  assign done          = doneReg;
`ifdef VECTOR_REGCODE_CHECK_EN
  assign err           = errReg;
`endif

  // Over-range handling: rejected when checking is built in, otherwise clamped to a full 16-register sweep.
  always_comb begin
`ifdef VECTOR_REGCODE_CHECK_EN
    overRange = (count > 5'd16);
    effCount  = count;
`else
    effCount  = (count > 5'd16) ? 5'd16 : count;
`endif
  end

  // Next-state and datapath updates; done/err are one-cycle pulses unless re-set here.
  always_comb begin
    stateNext = state;
    idxNext   = idx;
    remNext   = rem;
    stpNext   = stp;
    doneNext  = 1'b0;
`ifdef VECTOR_REGCODE_CHECK_EN
    errNext   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start_valid) begin
          idxNext = base_vector;
          remNext = effCount;
          stpNext = stepLow;
`ifdef VECTOR_REGCODE_CHECK_EN
          if (overRange) begin
            doneNext = 1'b1;
            errNext  = 1'b1;
          end else
`endif
          if (effCount == 5'd0) begin
            doneNext = 1'b1;
          end else begin
            stateNext = EMIT;
          end
        end
      end
      EMIT: begin
        if (code_ready) begin
          idxNext = idx + stp;
          remNext = rem - 5'd1;
          if (rem == 5'd1) begin
            stateNext = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register; reset abandons any request in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= 4'd0;
      rem     <= 5'd0;
      stp     <= 4'd0;
      doneReg <= 1'b0;
`ifdef VECTOR_REGCODE_CHECK_EN
      errReg  <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      idx     <= idxNext;
      rem     <= remNext;
      stp     <= stpNext;
      doneReg <= doneNext;
`ifdef VECTOR_REGCODE_CHECK_EN
      errReg  <= errNext;
`endif
    end
  end

endmodule

// File: tb/tb_vector_regcode_sequencer.sv
// Purpose: scoreboard bench for vector_regcode_sequencer; expected codes are queued at acceptance and popped on handshakes.
// Latency: inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
// Backpressure: code_ready is toggled by the driver to exercise stalls.
module tb_vector_regcode_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] base_vector;
  logic [4:0] count;
  logic [3:0] step;
  logic       code_valid;
  logic       code_ready;
  logic [4:0] register_code;
  logic       last;
  logic       done;
  logic       busy;
`ifdef VECTOR_REGCODE_CHECK_EN
  logic       err;
  int         errCyc = -1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int zeroCyc = -1;
  logic prevLast = 1'b0;
  logic [5:0] q[$];   // {last, code}

  vector_regcode_sequencer #(.STEP_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .base_vector(base_vector),
    .count(count),
    .step(step),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .register_code(register_code),
    .last(last),
    .done(done),
    .busy(busy)
`ifdef VECTOR_REGCODE_CHECK_EN
    ,
    .err(err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor: compares every handshake against the scoreboard and checks done/err timing.
  always @(negedge clk) begin
    if (rst) begin
      prevLast = 1'b0;
    end else begin
      chk("done", done, prevLast || (zeroCyc == cyc));
`ifdef VECTOR_REGCODE_CHECK_EN
      chk("err", err, errCyc == cyc);
`endif
      chk("codeValid", code_valid, q.size() != 0);
      if (code_valid && q.size() != 0) begin
        chk("code", register_code, q[0][4:0]);
        chk("last", last, q[0][5]);
        chk("busy", busy, 1);
        if (code_ready) begin
          prevLast = q[0][5];
          void'(q.pop_front());
        end else begin
          prevLast = 1'b0;
        end
      end else begin
        prevLast = 1'b0;
      end
    end
  end

  // Presents a request, waits for acceptance and queues the codes it must produce.
  task automatic sendReq(input logic [3:0] b, input logic [4:0] c, input logic [3:0] s);
    int waits = 0;
    int eff;
    logic [3:0] ix;
    base_vector = b;
    count = c;
    step = s;
    start_valid = 1'b1;
    while (!start_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    chk("reqReady", start_ready, 1);
    @(posedge clk); #1;
    start_valid = 1'b0;
    eff = int'(c);
`ifdef VECTOR_REGCODE_CHECK_EN
    if (c > 5'd16) begin
      errCyc = cyc;
      eff = 0;
    end
`else
    if (c > 5'd16) eff = 16;
`endif
    if (eff == 0) zeroCyc = cyc;
    ix = b;
    for (int i = 0; i < eff; i++) begin
      q.push_back({(i == eff - 1), 1'b1, ix});
      ix = ix + s;
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((q.size() != 0 || busy || done) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idleTimeout", n < 100, 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    start_valid = 1'b0;
    base_vector = 4'd0;
    count = 5'd0;
    step = 4'd0;
    code_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstValid", code_valid, 0);
    chk("rstCode", register_code, 16);
    chk("rstLast", last, 0);
    chk("rstDone", done, 0);
    chk("rstBusy", busy, 0);
    chk("rstReadyLow", start_ready, 0);
`ifdef VECTOR_REGCODE_CHECK_EN
    chk("rstErr", err, 0);
`endif
    rst = 1'b0;
    #1;
    chk("readyAfterRst", start_ready, 1);
    @(posedge clk); #1;

    // Contiguous run: 18..21
    sendReq(4'd2, 5'd4, 4'd1);
    waitIdle();

    // Wrap and stride: 30, 17, 20
    sendReq(4'd14, 5'd3, 4'd3);
    waitIdle();

    // Backpressure: code 16 held four cycles, then 17
    code_ready = 1'b0;
    sendReq(4'd0, 5'd2, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    code_ready = 1'b1;
    waitIdle();

    // Zero count: done only
    sendReq(4'd5, 5'd0, 4'd1);
    waitIdle();

    // Back-to-back: second request accepted in the done cycle
    sendReq(4'd7, 5'd2, 4'd2);
    n = 0;
    while (!done && n < 50) begin @(posedge clk); #1; n++; end
    chk("b2bDone", done, 1);
    chk("b2bReady", start_ready, 1);
    sendReq(4'd9, 5'd1, 4'd0);
    waitIdle();

    // Zero stride repeats the same code
    sendReq(4'd9, 5'd3, 4'd0);
    waitIdle();

    // Over-range count
    sendReq(4'd5, 5'd20, 4'd1);
    waitIdle();

    // Reset mid-EMIT abandons the request
    sendReq(4'd3, 5'd10, 4'd1);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    chk("midRstValid", code_valid, 0);
    chk("midRstCode", register_code, 16);
    chk("midRstDone", done, 0);
    chk("midRstBusy", busy, 0);
    chk("midRstReady", start_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midRstReadyAfter", start_ready, 1);
    repeat (3) begin @(posedge clk); #1; end

    // Recovery after reset
    sendReq(4'd15, 5'd2, 4'd1);
    waitIdle();
    repeat (2) begin @(posedge clk); #1; end
    chk("queueEmpty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
